ssf_core_sched: RTL and testbench

//  Parametrised scheduler for an array of ssf cores sharing one io_in stream.
//  - Releases per-core resets one core at a time, STAGGER cycles apart.
//  - Arbitrates the cores' io_out/out_en into a single registered output.
//  - Adds round-robin mode, halt/restart, masking of cores still in reset, and collision reporting.
//  - Core instances live in the parent; this block only sequences and arbitrates.

---
 rtl/ssf_pkg.sv | 21 ++
 rtl/ssf_out_arbiter.sv | 93 +++++++++
 rtl/ssf_core_sched.sv | 130 +++++++++++++
 tb/tb_ssf_core_sched.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/ssf_pkg.sv
// Shared types and constants for the ssf core scheduler and its output arbiter.
package ssf_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2
    } sched_state_t;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    localparam logic [1:0] OE_IDLE  = 2'd0;
    localparam logic [1:0] OE_VALID = 2'd1;

    // Width of a core index: never narrower than one bit.
    function automatic int idx_width(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ssf_out_arbiter.sv
// Picks one core per cycle from the candidate mask and registers its data.
// Owns the output registers, the round-robin pointer, collision and drop_cnt.
module ssf_out_arbiter
    import ssf_pkg::*;
#(
    parameter int N_CORES = 48,
    parameter int DATA_W  = 32,
    parameter int MODE    = ARB_FIXED,
    localparam int IDX_W  = idx_width(N_CORES)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear,
    input  logic [N_CORES-1:0]          cand,
    input  logic [N_CORES*DATA_W-1:0]   data,
    output logic [DATA_W-1:0]           io_out,
    output logic [1:0]                  out_en,
    output logic [IDX_W-1:0]            out_idx,
    output logic                        collision,
    output logic [15:0]                 drop_cnt
);

    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  win;
    logic              found;
    logic              multi;
    logic              seen;
    logic [DATA_W-1:0] win_data;

    // Winner selection and multi-candidate detection.
    always_comb begin
        win   = '0;
        found = 1'b0;
        multi = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < N_CORES; i++) begin
            if (cand[i]) begin
                if (seen) multi = 1'b1;
                seen = 1'b1;
            end
        end
        if (MODE == ARB_RR) begin
            // Search starts strictly after the pointer and wraps to 0.
            for (int i = 1; i <= N_CORES; i++) begin
                int k;
                k = int'(rr_ptr) + i;
                if (k >= N_CORES) k = k - N_CORES;
                if (!found && cand[k]) begin
                    found = 1'b1;
                    win   = IDX_W'(k);
                end
            end
        end else begin
            for (int i = 0; i < N_CORES; i++) begin
                if (!found && cand[i]) begin
                    found = 1'b1;
                    win   = IDX_W'(i);
                end
            end
        end
        win_data = data[int'(win)*DATA_W +: DATA_W];
    end

    // Registered output, pointer and collision accounting.
    always_ff @(posedge clk) begin
        if (rst) begin
            io_out    <= '0;
            out_en    <= OE_IDLE;
            out_idx   <= '0;
            collision <= 1'b0;
            drop_cnt  <= '0;
            rr_ptr    <= IDX_W'(N_CORES - 1);
        end else if (clear) begin
            io_out    <= '0;
            out_en    <= OE_IDLE;
            out_idx   <= '0;
            collision <= 1'b0;
        end else begin
            if (found) begin
                io_out  <= win_data;
                out_en  <= OE_VALID;
                out_idx <= win;
                rr_ptr  <= win;
            end else begin
                io_out  <= '0;
                out_en  <= OE_IDLE;
            end
            collision <= multi;
            if (multi && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
        end
    end

endmodule

// File: rtl/ssf_core_sched.sv
// Staggered reset release for an array of ssf cores plus output arbitration.
// Handshake: a core offers a word when its out_en is 2'd1 and its reset is
// released; the registered out_en of 2'd1 marks io_out valid for one cycle,
// there is no back-pressure.
module ssf_core_sched
    import ssf_pkg::*;
#(
    parameter int N_CORES    = 48,
    parameter int DATA_W     = 32,
    parameter int STAGGER    = 660,
    parameter int MODE       = ARB_FIXED,
    parameter int AUTO_START = 1,
    localparam int IDX_W     = idx_width(N_CORES),
    localparam int CNT_W     = $clog2(STAGGER + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        halt,
    output logic [N_CORES-1:0]          core_rst,
    input  logic [N_CORES*DATA_W-1:0]   core_io_out,
    input  logic [2*N_CORES-1:0]        core_out_en,
    output logic [DATA_W-1:0]           io_out,
    output logic [1:0]                  out_en,
    output logic [IDX_W-1:0]            out_idx,
    output logic                        busy,
    output logic                        all_released,
    output logic                        collision,
    output logic [15:0]                 drop_cnt,
    output sched_state_t                dbg_state
);

    sched_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_nxt;
    logic             auto_pending;
    logic             go;
    logic             step;
    logic             last_step;
    logic [N_CORES-1:0] cand;

    assign idx_nxt   = idx + IDX_W'(1);
    assign go        = start || auto_pending;
    assign step      = (cnt == CNT_W'(STAGGER - 1));
    assign last_step = step && (idx == IDX_W'(N_CORES - 2));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; halt always wins over start.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!halt && go) state_d = RELEASE;
            RELEASE: if (halt) state_d = IDLE;
                     else if (last_step) state_d = RUN;
            RUN:     if (halt) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Status outputs decoded from the state.
    always_comb begin
        busy         = (state_q == RELEASE);
        all_released = (state_q == RUN);
        dbg_state    = state_q;
    end

    // Release counter, release index and per-core resets.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt          <= '0;
            idx          <= '0;
            core_rst     <= '1;
            auto_pending <= (AUTO_START != 0);
        end else begin
            auto_pending <= 1'b0;
            if (halt) begin
                cnt      <= '0;
                idx      <= '0;
                core_rst <= '1;
            end else begin
                case (state_q)
                    IDLE: if (go) begin
                        core_rst[0] <= 1'b0;
                        cnt         <= '0;
                        idx         <= '0;
                    end
                    RELEASE: if (step) begin
                        cnt               <= '0;
                        idx               <= idx_nxt;
                        core_rst[idx_nxt] <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

    // A core is a candidate only when it signals valid and is out of reset.
    always_comb begin
        cand = '0;
        for (int k = 0; k < N_CORES; k++)
            cand[k] = (core_out_en[2*k +: 2] == OE_VALID) && !core_rst[k];
    end

    ssf_out_arbiter #(
        .N_CORES (N_CORES),
        .DATA_W  (DATA_W),
        .MODE    (MODE)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .clear     (halt && (state_q != IDLE)),
        .cand      (cand),
        .data      (core_io_out),
        .io_out    (io_out),
        .out_en    (out_en),
        .out_idx   (out_idx),
        .collision (collision),
        .drop_cnt  (drop_cnt)
    );

endmodule

// File: tb/tb_ssf_core_sched.sv
// Directed bench for ssf_core_sched: one fixed-priority and one round-robin
// instance share the same stimulus (4 cores, STAGGER 5, DATA_W 32).
module tb_ssf_core_sched;
    import ssf_pkg::*;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int ST = 5;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic            halt = 1'b0;
    logic [N*DW-1:0] core_io_out = '0;
    logic [2*N-1:0]  core_out_en = '0;

    logic [N-1:0]  core_rst0, core_rst1;
    logic [DW-1:0] io_out0, io_out1;
    logic [1:0]    out_en0, out_en1;
    logic [1:0]    out_idx0, out_idx1;
    logic          busy0, busy1, allr0, allr1, coll0, coll1;
    logic [15:0]   drop0, drop1;
    sched_state_t  st0, st1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ssf_core_sched #(.N_CORES(N), .DATA_W(DW), .STAGGER(ST), .MODE(ARB_FIXED), .AUTO_START(1)) dut0 (
        .clk(clk), .rst(rst), .start(start), .halt(halt), .core_rst(core_rst0),
        .core_io_out(core_io_out), .core_out_en(core_out_en), .io_out(io_out0),
        .out_en(out_en0), .out_idx(out_idx0), .busy(busy0), .all_released(allr0),
        .collision(coll0), .drop_cnt(drop0), .dbg_state(st0));

    ssf_core_sched #(.N_CORES(N), .DATA_W(DW), .STAGGER(ST), .MODE(ARB_RR), .AUTO_START(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .halt(halt), .core_rst(core_rst1),
        .core_io_out(core_io_out), .core_out_en(core_out_en), .io_out(io_out1),
        .out_en(out_en1), .out_idx(out_idx1), .busy(busy1), .all_released(allr1),
        .collision(coll1), .drop_cnt(drop1), .dbg_state(st1));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_core(input int k, input logic [1:0] en, input logic [DW-1:0] d);
        core_out_en[2*k +: 2] = en;
        core_io_out[k*DW +: DW] = d;
    endtask

    task automatic clear_cores();
        core_out_en = '0;
        core_io_out = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_checks++; if (core_rst0 !== 4'b1111) begin n_fail++; $display("FAIL reset_core_rst got %b exp 1111", core_rst0); end
        n_checks++; if (io_out0 !== 32'd0) begin n_fail++; $display("FAIL reset_io_out got %h exp 0", io_out0); end
        n_checks++; if (out_en0 !== 2'd0) begin n_fail++; $display("FAIL reset_out_en got %0d exp 0", out_en0); end
        n_checks++; if (out_idx0 !== 2'd0) begin n_fail++; $display("FAIL reset_out_idx got %0d exp 0", out_idx0); end
        n_checks++; if (coll0 !== 1'b0 || drop0 !== 16'd0) begin n_fail++; $display("FAIL reset_collision got %b/%0d exp 0/0", coll0, drop0); end
        n_checks++; if (st0 !== IDLE || busy0 !== 1'b0 || allr0 !== 1'b0) begin n_fail++; $display("FAIL reset_state got %0d busy %b allr %b exp IDLE 0 0", st0, busy0, allr0); end
    endtask

    task automatic test_release();
        logic [N-1:0] exp_rst;
        rst = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            tick();
            exp_rst = (e >= 16) ? 4'b0000 : (e >= 11) ? 4'b1000 : (e >= 6) ? 4'b1100 : 4'b1110;
            n_checks++; if (core_rst0 !== exp_rst) begin n_fail++; $display("FAIL release_core_rst edge %0d got %b exp %b", e, core_rst0, exp_rst); end
            n_checks++; if (busy0 !== (e <= 15)) begin n_fail++; $display("FAIL release_busy edge %0d got %b exp %b", e, busy0, (e <= 15)); end
            n_checks++; if (allr0 !== (e >= 16)) begin n_fail++; $display("FAIL release_all_released edge %0d got %b exp %b", e, allr0, (e >= 16)); end
        end
        n_checks++; if (core_rst1 !== 4'b0000 || st1 !== RUN) begin n_fail++; $display("FAIL release_rr_inst got %b/%0d exp 0000/RUN", core_rst1, st1); end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_idx [4];
        exp_idx[0] = 2'd0; exp_idx[1] = 2'd2; exp_idx[2] = 2'd3; exp_idx[3] = 2'd0;
        set_core(0, 2'd1, 32'd100);
        set_core(2, 2'd1, 32'd102);
        set_core(3, 2'd1, 32'd103);
        for (int c = 0; c < 4; c++) begin
            tick();
            n_checks++; if (out_idx1 !== exp_idx[c] || out_en1 !== 2'd1) begin n_fail++; $display("FAIL rr_grant cycle %0d got idx %0d en %0d exp idx %0d en 1", c, out_idx1, out_en1, exp_idx[c]); end
            n_checks++; if (io_out1 !== 32'd100 + 32'(exp_idx[c])) begin n_fail++; $display("FAIL rr_data cycle %0d got %0d exp %0d", c, io_out1, 100 + exp_idx[c]); end
            n_checks++; if (out_idx0 !== 2'd0) begin n_fail++; $display("FAIL fixed_during_rr cycle %0d got %0d exp 0", c, out_idx0); end
        end
        n_checks++; if (drop1 !== 16'd4 || coll1 !== 1'b1) begin n_fail++; $display("FAIL rr_drop_cnt got %0d coll %b exp 4 1", drop1, coll1); end
        clear_cores();
    endtask

    task automatic test_fixed_prio();
        set_core(1, 2'd1, 32'd7);
        set_core(3, 2'd1, 32'hFFFF_FFF7);
        tick();
        n_checks++; if (io_out0 !== 32'd7 || out_idx0 !== 2'd1 || out_en0 !== 2'd1) begin n_fail++; $display("FAIL fixed_grant got %0d idx %0d en %0d exp 7 1 1", io_out0, out_idx0, out_en0); end
        n_checks++; if (coll0 !== 1'b1 || drop0 !== 16'd5) begin n_fail++; $display("FAIL fixed_collision got %b cnt %0d exp 1 5", coll0, drop0); end
        n_checks++; if (out_idx1 !== 2'd1 || io_out1 !== 32'd7) begin n_fail++; $display("FAIL rr_after_ptr0 got idx %0d data %0d exp 1 7", out_idx1, io_out1); end
        set_core(1, 2'd0, 32'd0);
        tick();
        n_checks++; if (io_out1 !== 32'hFFFF_FFF7 || out_idx1 !== 2'd3) begin n_fail++; $display("FAIL rr_negative_data got %h idx %0d exp fffffff7 3", io_out1, out_idx1); end
        clear_cores();
        tick();
        n_checks++; if (out_en0 !== 2'd0 || io_out0 !== 32'd0 || out_idx0 !== 2'd3) begin n_fail++; $display("FAIL idle_hold got en %0d data %0d idx %0d exp 0 0 3", out_en0, io_out0, out_idx0); end
        n_checks++; if (coll0 !== 1'b0 || drop0 !== 16'd5) begin n_fail++; $display("FAIL idle_collision got %b cnt %0d exp 0 5", coll0, drop0); end
    endtask

    task automatic test_halt_restart();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (8) tick();
        n_checks++; if (core_rst0 !== 4'b1100) begin n_fail++; $display("FAIL halt_pre got %b exp 1100", core_rst0); end
        set_core(0, 2'd1, 32'd42);
        halt = 1'b1;
        tick();
        halt = 1'b0;
        clear_cores();
        n_checks++; if (core_rst0 !== 4'b1111 || st0 !== IDLE) begin n_fail++; $display("FAIL halt_effect got %b state %0d exp 1111 IDLE", core_rst0, st0); end
        n_checks++; if (out_en0 !== 2'd0 || busy0 !== 1'b0) begin n_fail++; $display("FAIL halt_out_en got %0d busy %b exp 0 0", out_en0, busy0); end
        repeat (2) tick();
        n_checks++; if (core_rst0 !== 4'b1111 || st0 !== IDLE) begin n_fail++; $display("FAIL halt_no_autostart got %b state %0d exp 1111 IDLE", core_rst0, st0); end
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++; if (core_rst0 !== 4'b1110 || busy0 !== 1'b1) begin n_fail++; $display("FAIL restart_first got %b busy %b exp 1110 1", core_rst0, busy0); end
        repeat (4) tick();
        n_checks++; if (core_rst0 !== 4'b1110) begin n_fail++; $display("FAIL restart_hold got %b exp 1110", core_rst0); end
        tick();
        n_checks++; if (core_rst0 !== 4'b1100) begin n_fail++; $display("FAIL restart_second got %b exp 1100", core_rst0); end
    endtask

    task automatic test_masking();
        set_core(0, 2'd2, 32'd10);
        set_core(1, 2'd3, 32'd11);
        set_core(2, 2'd1, 32'd5);
        set_core(3, 2'd1, 32'd13);
        tick();
        n_checks++; if (out_en0 !== 2'd0 || coll0 !== 1'b0) begin n_fail++; $display("FAIL mask_fixed got en %0d coll %b exp 0 0", out_en0, coll0); end
        n_checks++; if (out_en1 !== 2'd0 || coll1 !== 1'b0) begin n_fail++; $display("FAIL mask_rr got en %0d coll %b exp 0 0", out_en1, coll1); end
        set_core(1, 2'd1, 32'h55);
        tick();
        n_checks++; if (out_en0 !== 2'd1 || out_idx0 !== 2'd1 || io_out0 !== 32'h55) begin n_fail++; $display("FAIL mask_one_valid got en %0d idx %0d data %h exp 1 1 55", out_en0, out_idx0, io_out0); end
        n_checks++; if (coll0 !== 1'b0 || out_idx1 !== 2'd1) begin n_fail++; $display("FAIL mask_no_collision got coll %b rr idx %0d exp 0 1", coll0, out_idx1); end
        clear_cores();
    endtask

    task automatic test_halt_start_same();
        halt = 1'b1;
        start = 1'b1;
        tick();
        halt = 1'b0;
        start = 1'b0;
        n_checks++; if (st0 !== IDLE || core_rst0 !== 4'b1111) begin n_fail++; $display("FAIL halt_start got state %0d rst %b exp IDLE 1111", st0, core_rst0); end
        repeat (3) tick();
        n_checks++; if (st0 !== IDLE || busy0 !== 1'b0) begin n_fail++; $display("FAIL halt_start_stay got state %0d busy %b exp IDLE 0", st0, busy0); end
    endtask

    task automatic test_drop_saturate();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (16) tick();
        n_checks++; if (allr0 !== 1'b1 || drop0 !== 16'd0) begin n_fail++; $display("FAIL sat_setup got allr %b cnt %0d exp 1 0", allr0, drop0); end
        set_core(0, 2'd1, 32'd1);
        set_core(1, 2'd1, 32'd2);
        repeat (65535) tick();
        n_checks++; if (drop0 !== 16'hFFFF || drop1 !== 16'hFFFF) begin n_fail++; $display("FAIL sat_reach got %0d/%0d exp 65535", drop0, drop1); end
        tick();
        n_checks++; if (drop0 !== 16'hFFFF || coll0 !== 1'b1) begin n_fail++; $display("FAIL sat_hold got %0d coll %b exp 65535 1", drop0, coll0); end
        clear_cores();
        tick();
        halt = 1'b1;
        tick();
        halt = 1'b0;
        n_checks++; if (drop0 !== 16'hFFFF || st0 !== IDLE || out_en0 !== 2'd0) begin n_fail++; $display("FAIL sat_after_halt got %0d state %0d en %0d exp 65535 IDLE 0", drop0, st0, out_en0); end
    endtask

    initial begin
        test_reset();
        test_release();
        test_round_robin();
        test_fixed_prio();
        test_halt_restart();
        test_masking();
        test_halt_start_same();
        test_drop_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
